// File: rtl/starflux_pkg.sv
// Shared constants, types and helpers for the Starflux bullet logic.
//   DIR_UP_C / DIR_DOWN_C : values for the DIR_UP parameter
//   div_cnt_t             : 28-bit step divider counter
//   clog2_min1()          : $clog2 with a floor of 1, for index widths
package starflux_pkg;

    localparam bit DIR_UP_C   = 1'b1;
    localparam bit DIR_DOWN_C = 1'b0;

    localparam int unsigned DIV_W = 28;
    typedef logic [DIV_W-1:0] div_cnt_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bullet_lane_grid_if.sv
// Fire / clear request bundle for bullet_lane_grid.
//   master : fire control + collision logic (drives requests, sees fire_ready)
//   slave  : bullet_lane_grid
//   LW = lane index width, RW = row index width
interface bullet_lane_grid_if #(
    parameter int unsigned LW = 2,
    parameter int unsigned RW = 7
);
    logic          fire_valid;
    logic [LW-1:0] fire_lane;
    logic          fire_ready;
    logic          clear_valid;
    logic [LW-1:0] clear_lane;
    logic [RW-1:0] clear_row;

    modport master (
        output fire_valid, fire_lane, clear_valid, clear_lane, clear_row,
        input  fire_ready
    );

    modport slave (
        input  fire_valid, fire_lane, clear_valid, clear_lane, clear_row,
        output fire_ready
    );
endinterface

// File: rtl/bullet_lane_grid_step_divider.sv
// step_divider: free-running tick generator.
//   clk, reset_n (async, active-low), enable -> step
//   Counter starts at DIV_COUNT-1 and counts down while enabled; step is high
//   for the cycle in which it sits at 0 (it reloads on that edge).
module step_divider
    import starflux_pkg::*;
#(
    parameter int unsigned DIV_COUNT = 833333
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic step
);
    localparam div_cnt_t RELOAD = div_cnt_t'(DIV_COUNT - 1);

    div_cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (enable) begin
            if (cnt_q == '0) begin
                cnt_d = RELOAD;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= RELOAD;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bullet_lane_grid.sv
// bullet_lane_grid: LANES columns x DEPTH rows of single-bit bullets that
// shift one row per step toward row 0 (DIR_UP=1) or row DEPTH-1 (DIR_UP=0).
//   clk, reset_n  : clock, async active-low reset
//   enable        : runs the divider and allows fire; clears work regardless
//   bus (slave)   : fire_valid/fire_lane/fire_ready, clear_valid/lane/row
//   step          : one-cycle pulse on each shift
//   grid          : bit [l*DEPTH+r] = bullet at lane l, row r
//   escape        : one-cycle pulse per lane when a bullet leaves the screen
//   live_count    : registered popcount of grid (one cycle behind)
// Optional macro STARFLUX_FIRE_COOLDOWN_EN: per-lane cooldown of COOLDOWN
// steps after each injection, during which that lane refuses fire.
module bullet_lane_grid
    import starflux_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 120,
    parameter int unsigned DIV_COUNT = 833333,
    parameter bit          DIR_UP    = 1'b1,
    parameter int unsigned COOLDOWN  = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    bullet_lane_grid_if.slave                   bus,
    output logic                                step,
    output logic [LANES*DEPTH-1:0]              grid,
    output logic [LANES-1:0]                    escape,
    output logic [$clog2(LANES*DEPTH+1)-1:0]    live_count
);
    localparam int unsigned LW = clog2_min1(LANES);
    localparam int unsigned CW = $clog2(LANES*DEPTH+1);

    logic [LANES-1:0][DEPTH-1:0] grid_q, grid_d;
    logic [LANES-1:0]            pending_q, pending_d;
    logic [LANES-1:0]            escape_q, escape_d;
    logic [CW-1:0]               live_q, live_d;
    logic                        lane_ok;

`ifdef STARFLUX_FIRE_COOLDOWN_EN
    localparam int unsigned CDW = clog2_min1(COOLDOWN + 1);
    logic [LANES-1:0][CDW-1:0]   cd_q, cd_d;
`endif

    step_divider #(.DIV_COUNT(DIV_COUNT)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .step    (step)
    );

    // Lane select by compare; an out-of-range lane matches nothing and stays not-ready.
    always_comb begin
        lane_ok = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (bus.fire_lane == LW'(l)) begin
                lane_ok = !pending_q[l];
`ifdef STARFLUX_FIRE_COOLDOWN_EN
                if (cd_q[l] != '0) lane_ok = 1'b0;
`endif
            end
        end
    end

    assign bus.fire_ready = enable && lane_ok;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic             accept, inj, exit_bit;
        logic [DEPTH-1:0] clr_mask, kept, shifted;

        assign accept = bus.fire_valid && bus.fire_ready && (bus.fire_lane == LW'(l));
        assign inj    = pending_q[l] | accept;

        // Rows >= DEPTH shift the one-hot off the top, giving an empty mask.
        assign clr_mask = (bus.clear_valid && bus.clear_lane == LW'(l))
                        ? (DEPTH'(1) << bus.clear_row) : '0;
        // Clear is applied before the shift, so a cleared bit never moves or escapes.
        assign kept = grid_q[l] & ~clr_mask;

        if (DIR_UP == DIR_UP_C) begin : g_up
            assign shifted  = {inj, kept[DEPTH-1:1]};
            assign exit_bit = kept[0];
        end else begin : g_down
            assign shifted  = {kept[DEPTH-2:0], inj};
            assign exit_bit = kept[DEPTH-1];
        end

        assign grid_d[l]    = step ? shifted : kept;
        assign escape_d[l]  = step && exit_bit;
        assign pending_d[l] = step ? 1'b0 : (pending_q[l] | accept);

`ifdef STARFLUX_FIRE_COOLDOWN_EN
        assign cd_d[l] = !step           ? cd_q[l] :
                         inj             ? CDW'(COOLDOWN) :
                         (cd_q[l] != '0) ? cd_q[l] - 1'b1 : '0;
`endif
    end

    always_comb begin
        live_d = '0;
        for (int unsigned i = 0; i < LANES*DEPTH; i++) begin
            live_d = live_d + CW'(grid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grid_q    <= '0;
            pending_q <= '0;
            escape_q  <= '0;
            live_q    <= '0;
`ifdef STARFLUX_FIRE_COOLDOWN_EN
            cd_q      <= '0;
`endif
        end else begin
            grid_q    <= grid_d;
            pending_q <= pending_d;
            escape_q  <= escape_d;
            live_q    <= live_d;
`ifdef STARFLUX_FIRE_COOLDOWN_EN
            cd_q      <= cd_d;
`endif
        end
    end

    assign grid       = grid_q;
    assign escape     = escape_q;
    assign live_count = live_q;
endmodule

// File: tb/tb_bullet_lane_grid.sv
// Scoreboard bench for bullet_lane_grid (LANES=4, DEPTH=8, DIV_COUNT=4,
// DIR_UP=1, COOLDOWN=3). The reference model tracks bullets as a list of
// (lane,row) positions and derives step timing from a count of enabled cycles.
module tb_bullet_lane_grid;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int DIV   = 4;
    localparam int CD    = 3;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        step;
    logic [31:0] grid;
    logic [3:0]  escape;
    logic [5:0]  live_count;

    bullet_lane_grid_if #(.LW(2), .RW(3)) bus_if ();

    bullet_lane_grid #(
        .LANES(LANES), .DEPTH(DEPTH), .DIV_COUNT(DIV), .DIR_UP(1'b1), .COOLDOWN(CD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus_if.slave),
        .step(step), .grid(grid), .escape(escape), .live_count(live_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int lane; int row; } bul_t;
    typedef struct { logic stp; logic rdy; logic [31:0] grd; logic [3:0] esc; int live; } exp_t;

    bul_t     bq[$];
    exp_t     sbq[$];
    bit [3:0] pend;
    int       cd[4];
    int       en_cycles;
    logic [3:0] esc_prev;
    int       live_prev;
    int       n_cmp = 0;
    int       n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_grid();
        logic [31:0] g = '0;
        foreach (bq[i]) g[bq[i].lane*DEPTH + bq[i].row] = 1'b1;
        return g;
    endfunction

    function automatic bit step_next(input bit en);
        return en && (en_cycles % DIV == DIV - 1);
    endfunction

    task automatic model_reset();
        bq.delete();
        pend = '0;
        for (int l = 0; l < 4; l++) cd[l] = 0;
        en_cycles = 0;
        esc_prev = '0;
        live_prev = 0;
    endtask

    // One clock: drive inputs, push expected outputs, advance the model.
    task automatic do_cycle(input bit en, input bit fv, input int fl,
                            input bit cv, input int cl, input int cr);
        exp_t e;
        bul_t nq[$];
        logic [3:0] esc_n;
        bit acc;
        @(posedge clk);
        #1;
        enable = en;
        bus_if.fire_valid  = fv;
        bus_if.fire_lane   = 2'(fl);
        bus_if.clear_valid = cv;
        bus_if.clear_lane  = 2'(cl);
        bus_if.clear_row   = 3'(cr);

        e.grd  = model_grid();
        e.stp  = step_next(en);
        e.rdy  = en && !pend[fl];
`ifdef STARFLUX_FIRE_COOLDOWN_EN
        if (cd[fl] != 0) e.rdy = 1'b0;
`endif
        e.esc  = esc_prev;
        e.live = live_prev;
        sbq.push_back(e);

        acc = fv && e.rdy;
        if (cv) begin
            foreach (bq[i]) if (!(bq[i].lane == cl && bq[i].row == cr)) nq.push_back(bq[i]);
            bq = nq;
            nq.delete();
        end
        esc_n = '0;
        if (e.stp) begin
            foreach (bq[i]) begin
                if (bq[i].row == 0) esc_n[bq[i].lane] = 1'b1;
                else nq.push_back('{bq[i].lane, bq[i].row - 1});
            end
            for (int l = 0; l < LANES; l++) begin
                if (pend[l] || (acc && fl == l)) begin
                    nq.push_back('{l, DEPTH - 1});
                    cd[l] = CD;
                end else if (cd[l] > 0) begin
                    cd[l] = cd[l] - 1;
                end
            end
            bq = nq;
            pend = '0;
        end else if (acc) begin
            pend[fl] = 1'b1;
        end
        esc_prev  = esc_n;
        live_prev = $countones(e.grd);
        if (en) en_cycles++;
    endtask

    task automatic idle_inputs();
        enable = 1'b0;
        bus_if.fire_valid = 1'b0;
        bus_if.fire_lane = '0;
        bus_if.clear_valid = 1'b0;
        bus_if.clear_lane = '0;
        bus_if.clear_row = '0;
    endtask

    task automatic rand_cycle();
        bit en = ($urandom_range(0, 9) != 0);
        bit fv = ($urandom_range(0, 2) == 0);
        int fl = $urandom_range(0, 3);
        bit cv = ($urandom_range(0, 3) == 0);
        int cl = $urandom_range(0, 3);
        int cr = $urandom_range(0, 7);
        if (cv && bq.size() > 0 && $urandom_range(0, 1) == 1) begin
            int k = $urandom_range(0, bq.size() - 1);
            cl = bq[k].lane;
            cr = bq[k].row;
        end
        do_cycle(en, fv, fl, cv, cl, cr);
    endtask

    // Monitor: compares whatever the stimulus side queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("step",       32'(step),       32'(e.stp));
                check("fire_ready", 32'(bus_if.fire_ready), 32'(e.rdy));
                check("grid",       grid,            e.grd);
                check("escape",     32'(escape),     32'(e.esc));
                check("live_count", 32'(live_count), 32'(e.live));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #7 reset_n = 1'b1;

        // Idle enabled cycles: step cadence and reset outputs.
        repeat (6) do_cycle(1, 0, 0, 0, 0, 0);

        // Fire lane 2 off a step boundary and let it fly off-screen.
        while (step_next(1)) do_cycle(1, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 2, 0, 0, 0);
        repeat (40) do_cycle(1, 0, 0, 0, 0, 0);

        // Fire lane 1 exactly on a step, then clear it at row 5 on a step.
        for (int i = 0; i < 8 && !step_next(1); i++) do_cycle(1, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            bit hit = 1'b0;
            foreach (bq[k]) if (bq[k].lane == 1 && bq[k].row == 5) hit = 1'b1;
            if (hit && step_next(1)) begin
                do_cycle(1, 0, 0, 1, 1, 5);
                break;
            end
            do_cycle(1, 0, 0, 0, 0, 0);
        end
        repeat (12) do_cycle(1, 0, 0, 0, 0, 0);

        // Lane 0 twice back to back: cooldown stall when the macro is on.
        do_cycle(1, 1, 0, 0, 0, 0);
        repeat (30) do_cycle(1, 1, 0, 0, 0, 0);

        repeat (2500) rand_cycle();

        // Async reset with several bullets in flight.
        for (int i = 0; i < 200 && bq.size() < 3; i++) do_cycle(1, 1, $urandom_range(0, 3), 0, 0, 0);
        if (bq.size() < 3) begin
            n_cmp++;
            n_bad++;
            $display("FAIL preload: got %0d bullets expected at least 3", bq.size());
        end
        #6;
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset_grid",   grid,            32'h0);
        check("reset_escape", 32'(escape),     32'h0);
        check("reset_live",   32'(live_count), 32'h0);
        check("reset_step",   32'(step),       32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #7 reset_n = 1'b1;
        repeat (10) do_cycle(1, 0, 0, 0, 0, 0);

        repeat (1500) rand_cycle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
